// File: rtl/reg_map_pkg.sv
// reg_map_pkg: ILA bus window base, register offsets and capture state encoding
package reg_map_pkg;
   localparam logic [31:0] BASE_ILA      = 32'h2000_0000;
   localparam logic [19:0] ILA_CTRL      = 20'h0_0000;
   localparam logic [19:0] ILA_STATUS    = 20'h0_0004;
   localparam logic [19:0] ILA_PRETRIG   = 20'h0_0008;
   localparam logic [19:0] ILA_TRIG_ADDR = 20'h0_000C;
   localparam logic [19:0] ILA_INFO      = 20'h0_0010;
   localparam logic [19:0] ILA_RAM       = 20'h8_0000;
   typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_WAIT, ST_POST, ST_DONE} ila_state_t;
endpackage

// File: rtl/ila_core_if.sv
// ila_core_if: 32-bit register bus between the SPI bridge (master) and the ILA (slave)
interface ila_core_if;
   logic [31:0] bus_addr;
   logic        bus_wen;
   logic        bus_ren;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   modport master (output bus_addr, bus_wen, bus_ren, bus_wdata, input bus_rdata);
   modport slave (input bus_addr, bus_wen, bus_ren, bus_wdata, output bus_rdata);
endinterface

// File: rtl/ila_sample_ram.sv
// ila_sample_ram: simple dual-port sample buffer, one write port and one registered read port
module ila_sample_ram #(
   parameter int W     = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   // write the capture sample and register the bus-side read word
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/ila_core.sv
// ila_core: circular-buffer logic analyser with trigger, post-trigger countdown and bus readout
module ila_core import reg_map_pkg::*; #(
   parameter logic [31:0] BASE_ADDR = BASE_ILA,
   parameter int          SAMPLE_W  = 32,
   parameter int          DEPTH     = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                trigger_in,
   input  logic [SAMPLE_W-1:0] sample_in,
   ila_core_if.slave           bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PRE_RST = AW'(DEPTH / 2);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [31:0] INFO = {8'd0, 8'(SAMPLE_W), 16'(DEPTH)};
   ila_state_t state, nxt;
   logic [AW-1:0] wptr, cnt, post, pretrig, pre_s, trig_addr;
   logic [19:0] off;
   logic sel, wr, ctrl_wr, arm, abort, frc, we, trig, ram_hit, ram_sel_q, unused_ren;
   logic [2:0] status;
   logic [31:0] rd_val, reg_q;
   logic [SAMPLE_W-1:0] ram_q;
   assign off = bus.bus_addr[19:0];
   assign sel = bus.bus_addr[31:20] == BASE_ADDR[31:20];
   assign wr = sel && bus.bus_wen;
   assign ctrl_wr = wr && off == ILA_CTRL;
   assign arm = ctrl_wr && bus.bus_wdata[0];
   assign frc = ctrl_wr && bus.bus_wdata[1];
   assign abort = ctrl_wr && bus.bus_wdata[2];
   assign unused_ren = bus.bus_ren;
   // next state and RAM write enable; ABORT beats ARM beats trigger/FORCE
   always_comb begin
      nxt = state;
      we = 1'b0;
      trig = 1'b0;
      if (abort) nxt = ST_IDLE;
      else if (arm) nxt = ST_FILL;
      else begin
         case (state)
            ST_FILL: begin
               we = pre_s != '0;
               nxt = (pre_s == '0 || cnt == pre_s - 1'b1) ? ST_WAIT : ST_FILL;
            end
            ST_WAIT: begin
               we = 1'b1;
               trig = trigger_in || frc;
               nxt = !trig ? ST_WAIT : (LAST == pre_s) ? ST_DONE : ST_POST;
            end
            ST_POST: begin
               we = 1'b1;
               nxt = (post == AW'(1)) ? ST_DONE : ST_POST;
            end
            default: ;
         endcase
      end
   end
   // capture state: write pointer, pre-trigger fill count, post-trigger countdown, trigger index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         wptr <= '0;
         cnt <= '0;
         post <= '0;
         pre_s <= PRE_RST;
         trig_addr <= '0;
      end else begin
         state <= nxt;
         if (arm && !abort) begin
            wptr <= '0;
            cnt <= '0;
            pre_s <= pretrig;
         end else if (!abort) begin
            if (we) wptr <= wptr + 1'b1;
            if (state == ST_FILL) cnt <= cnt + 1'b1;
            if (trig) begin
               trig_addr <= wptr;
               post <= LAST - pre_s;
            end else if (state == ST_POST) post <= post - 1'b1;
         end
      end
   end
   // PRETRIG register; oversized writes saturate at DEPTH-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pretrig <= PRE_RST;
      else if (wr && off == ILA_PRETRIG) pretrig <= (bus.bus_wdata > 32'(LAST)) ? LAST : bus.bus_wdata[AW-1:0];
   end
   assign status = {state == ST_DONE, state == ST_POST || state == ST_DONE, state != ST_IDLE};
   assign ram_hit = sel && off[19] && off[18:AW+2] == '0;
   assign rd_val = !sel ? '0 :
                   off == ILA_STATUS ? {29'd0, status} :
                   off == ILA_PRETRIG ? 32'(pretrig) :
                   off == ILA_TRIG_ADDR ? 32'(trig_addr) :
                   off == ILA_INFO ? INFO : '0;
   // register the read word; the RAM read port is registered alongside, selected after the flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q <= '0;
         ram_sel_q <= 1'b0;
      end else begin
         reg_q <= rd_val;
         ram_sel_q <= ram_hit;
      end
   end
   assign bus.bus_rdata = ram_sel_q ? 32'(ram_q) : reg_q;
   ila_sample_ram #(.W(SAMPLE_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wptr),
      .wdata (sample_in),
      .raddr (off[AW+1:2]),
      .rdata (ram_q)
   );
endmodule

// File: tb/tb_ila_core.sv
// tb_ila_core: directed checks of ILA capture, trigger, control priority and register decode
module tb_ila_core;
   import reg_map_pkg::*;
   localparam int DEPTH = 16;
   localparam logic [31:0] B = BASE_ILA;
   localparam logic [31:0] OUTSIDE = BASE_ILA + 32'h0010_0000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic trigger_in = 1'b0;
   logic [31:0] cyc = '0;
   logic [31:0] sample_in;
   logic [31:0] rv, c0, c1, ta, last_wr_cyc;
   int checks = 0;
   int errors = 0;
   ila_core_if bus ();
   ila_core #(.BASE_ADDR(BASE_ILA), .SAMPLE_W(32), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .trigger_in (trigger_in),
      .sample_in  (sample_in),
      .bus        (bus)
   );
   // clock and free-running sample counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;
   assign sample_in = cyc;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.bus_addr = a;
      bus.bus_wdata = d;
      bus.bus_wen = 1'b1;
      last_wr_cyc = cyc;
      @(negedge clk);
      bus.bus_wen = 1'b0;
   endtask
   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.bus_addr = a;
      bus.bus_ren = 1'b1;
      @(negedge clk);
      d = bus.bus_rdata;
      bus.bus_ren = 1'b0;
   endtask
   task automatic ram(input logic [31:0] i, output logic [31:0] d);
      rd(B + 32'(ILA_RAM) + ((i & 32'hF) << 2), d);
   endtask
   task automatic wait_done(input string tag);
      int n = 0;
      rd(B + 32'(ILA_STATUS), rv);
      while (!rv[2] && n < 64) begin
         rd(B + 32'(ILA_STATUS), rv);
         n++;
      end
      chk(tag, rv, 32'h7);
   endtask
   // directed sequence
   initial begin
      bus.bus_addr = B + 32'(ILA_INFO);
      bus.bus_wen = 1'b0;
      bus.bus_ren = 1'b0;
      bus.bus_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_rdata_low", bus.bus_rdata, 32'h0);
      rst_n = 1'b1;
      rd(B + 32'(ILA_STATUS), rv);    chk("rst_status", rv, 32'h0);
      rd(B + 32'(ILA_PRETRIG), rv);   chk("rst_pretrig", rv, 32'd8);
      rd(B + 32'(ILA_INFO), rv);      chk("rst_info", rv, 32'h0020_0010);
      rd(B + 32'(ILA_TRIG_ADDR), rv); chk("rst_trig_addr", rv, 32'h0);
      wr(B + 32'(ILA_PRETRIG), 32'd4);
      wr(B + 32'(ILA_CTRL), 32'h1);
      c0 = last_wr_cyc;
      rd(B + 32'(ILA_STATUS), rv);    chk("t1_armed", rv, 32'h1);
      while (cyc != 32'd100 && cyc < 32'd200) @(negedge clk);
      trigger_in = 1'b1;
      @(negedge clk);
      trigger_in = 1'b0;
      wait_done("t1_status");
      rd(B + 32'(ILA_TRIG_ADDR), ta); chk("t1_trig_addr", ta, (32'd99 - c0) & 32'hF);
      ram(ta, rv);                    chk("t1_ram_trig", rv, 32'd100);
      ram(ta - 32'd4, rv);            chk("t1_ram_pre4", rv, 32'd96);
      ram(ta + 32'd11, rv);           chk("t1_ram_post11", rv, 32'd111);
      wr(B + 32'(ILA_PRETRIG), 32'd8);
      trigger_in = 1'b1;
      wr(B + 32'(ILA_CTRL), 32'h1);
      c0 = last_wr_cyc;
      wait_done("t2_status");
      trigger_in = 1'b0;
      rd(B + 32'(ILA_TRIG_ADDR), ta); chk("t2_trig_addr", ta, 32'd8);
      ram(32'd8, rv);                 chk("t2_ram8", rv, c0 + 32'd9);
      ram(32'd0, rv);                 chk("t2_ram0", rv, c0 + 32'd1);
      ram(32'd15, rv);                chk("t2_ram15", rv, c0 + 32'd16);
      wr(B + 32'(ILA_PRETRIG), 32'd4);
      wr(B + 32'(ILA_CTRL), 32'h1);
      c0 = last_wr_cyc;
      repeat (8) @(negedge clk);
      wr(B + 32'(ILA_CTRL), 32'h2);
      c1 = last_wr_cyc;
      wait_done("t3_status");
      rd(B + 32'(ILA_TRIG_ADDR), ta); chk("t3_trig_addr", ta, (c1 - c0 - 32'd1) & 32'hF);
      ram(ta, rv);                    chk("t3_ram_force", rv, c1);
      ram(ta + 32'd11, rv);           chk("t3_ram_post11", rv, c1 + 32'd11);
      wr(B + 32'(ILA_PRETRIG), 32'd0);
      trigger_in = 1'b1;
      wr(B + 32'(ILA_CTRL), 32'h1);
      c0 = last_wr_cyc;
      wait_done("t4_status");
      trigger_in = 1'b0;
      rd(B + 32'(ILA_TRIG_ADDR), ta); chk("t4_trig_addr", ta, 32'd0);
      ram(32'd0, rv);                 chk("t4_ram0", rv, c0 + 32'd2);
      ram(32'd15, rv);                chk("t4_ram15", rv, c0 + 32'd17);
      wr(B + 32'(ILA_PRETRIG), 32'd4);
      wr(B + 32'(ILA_CTRL), 32'h1);
      repeat (8) @(negedge clk);
      wr(B + 32'(ILA_CTRL), 32'h2);
      wr(B + 32'(ILA_CTRL), 32'h1);
      rd(B + 32'(ILA_STATUS), rv);    chk("t5_rearm_post", rv, 32'h1);
      wr(B + 32'(ILA_CTRL), 32'h5);
      rd(B + 32'(ILA_STATUS), rv);    chk("t5_abort_arm", rv, 32'h0);
      rd(B + 32'h14, rv);             chk("t6_unmapped", rv, 32'h0);
      rd(B + 32'(ILA_RAM) + 32'd64, rv); chk("t6_ram_oob", rv, 32'h0);
      wr(B + 32'(ILA_PRETRIG), 32'd6);
      wr(OUTSIDE + 32'(ILA_PRETRIG), 32'd3);
      rd(B + 32'(ILA_PRETRIG), rv);   chk("t6_outside_pretrig", rv, 32'd6);
      wr(OUTSIDE + 32'(ILA_CTRL), 32'h1);
      rd(B + 32'(ILA_STATUS), rv);    chk("t6_outside_ctrl", rv, 32'h0);
      wr(B + 32'(ILA_PRETRIG), 32'd100);
      rd(B + 32'(ILA_PRETRIG), rv);   chk("t6_pretrig_clamp", rv, 32'd15);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
